menu_mode_controller: RTL and testbench

- Parametrised menu/mode state machine for the board top level.
- Qualifies the raw push-buttons, moves a menu cursor over NUM_APPS application entries, enters the selected application and returns to the menu.
- Drives machine_state, which the OLED source mux and the per-app modules consume. State 0 is the menu; states 1..NUM_APPS are applications.
- Improves on the single-counter scheme: each button has its own release counter, and apps can be individually disabled.

---
 rtl/menu_pkg.sv | 21 ++
 rtl/menu_mode_controller_if.sv | 27 ++
 rtl/btn_release_qualifier.sv | 60 ++++++
 rtl/menu_mode_controller.sv | 100 ++++++++++
 tb/tb_menu_mode_controller.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/menu_pkg.sv
// Shared types and helpers for the menu/mode controller and its button qualifiers.
package menu_pkg;

   localparam int unsigned MENU_STATE             = 0;
   localparam int unsigned DEFAULT_RELEASE_CYCLES = 6_250_000;

   typedef enum logic {StIdle, StPressed} qual_state_e;
   typedef enum logic {DirLeft, DirRight} dir_e;

   // Cursor lives in 1..num_apps; wrap selects wrap-around versus saturation at the ends.
   function automatic int unsigned next_cursor(int unsigned cursor, dir_e dir, bit wrap,
                                               int unsigned num_apps);
      if (dir == DirRight) begin
         if (cursor >= num_apps) return wrap ? 32'd1 : num_apps;
         return cursor + 32'd1;
      end
      if (cursor <= 32'd1) return wrap ? num_apps : 32'd1;
      return cursor - 32'd1;
   endfunction

endpackage

// File: rtl/menu_mode_controller_if.sv
// Button, enable and mode signals between the board top level and the menu controller.
interface menu_mode_controller_if #(
   parameter int unsigned NUM_APPS = 8,
   parameter int unsigned STATE_W  = $clog2(NUM_APPS + 1)
);

   logic                btnC;
   logic                btnL;
   logic                btnR;
   logic [NUM_APPS-1:0] app_enable;
   logic [STATE_W-1:0]  machine_state;
   logic [STATE_W-1:0]  menu_cursor;
   logic                enter_pulse;
   logic                exit_pulse;
   logic                reject_pulse;

   modport master (
      output btnC, btnL, btnR, app_enable,
      input  machine_state, menu_cursor, enter_pulse, exit_pulse, reject_pulse
   );

   modport slave (
      input  btnC, btnL, btnR, app_enable,
      output machine_state, menu_cursor, enter_pulse, exit_pulse, reject_pulse
   );

endinterface

// File: rtl/btn_release_qualifier.sv
// Synchronizes one raw push-button and emits a single-cycle event once it has been
// seen low for RELEASE_CYCLES consecutive cycles after a press.
module btn_release_qualifier
   import menu_pkg::*;
#(
   parameter int unsigned RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES,
   parameter int unsigned CNT_W          = $clog2(RELEASE_CYCLES + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic evt
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(RELEASE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   qual_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             evt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= StIdle;
         cnt_q   <= '0;
         evt_q   <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         evt_q   <= 1'b0;
         case (state_q)
            StIdle: begin
               if (sync2_q) begin
                  state_q <= StPressed;
                  cnt_q   <= '0;
               end
            end
            StPressed: begin
               // Any high sample (held or bounce) restarts the release count.
               if (sync2_q) begin
                  cnt_q <= '0;
               end else if (cnt_q == LastCnt) begin
                  evt_q   <= 1'b1;
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign evt = evt_q;

endmodule

// File: rtl/menu_mode_controller.sv
// Menu/application mode FSM: moves a cursor over NUM_APPS entries, enters enabled apps
// and returns to the menu; all outputs registered.
module menu_mode_controller
   import menu_pkg::*;
#(
   parameter int unsigned NUM_APPS       = 8,
   parameter int unsigned STATE_W        = $clog2(NUM_APPS + 1),
   parameter int unsigned RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES,
   parameter int unsigned CNT_W          = $clog2(RELEASE_CYCLES + 1),
   parameter bit          WRAP           = 1'b1
) (
   input logic                   clock,
   input logic                   reset,
   menu_mode_controller_if.slave bus
);

   localparam logic [STATE_W-1:0] MenuState = STATE_W'(MENU_STATE);

   logic               evt_c;
   logic               evt_l;
   logic               evt_r;
   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] cursor_q;
   logic               enter_q;
   logic               exit_q;
   logic               reject_q;
   logic               cursor_en;
   logic               state_en;

   btn_release_qualifier #(.RELEASE_CYCLES(RELEASE_CYCLES), .CNT_W(CNT_W)) u_qual_c (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (bus.btnC),
      .evt     (evt_c)
   );

   btn_release_qualifier #(.RELEASE_CYCLES(RELEASE_CYCLES), .CNT_W(CNT_W)) u_qual_l (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (bus.btnL),
      .evt     (evt_l)
   );

   btn_release_qualifier #(.RELEASE_CYCLES(RELEASE_CYCLES), .CNT_W(CNT_W)) u_qual_r (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (bus.btnR),
      .evt     (evt_r)
   );

   // Enable bit of the highlighted entry and of the running app (entry k maps to bit k-1).
   always_comb begin
      cursor_en = 1'b0;
      state_en  = 1'b0;
      for (int i = 0; i < NUM_APPS; i++) begin
         if (cursor_q == STATE_W'(i + 1)) cursor_en = bus.app_enable[i];
         if (state_q == STATE_W'(i + 1))  state_en  = bus.app_enable[i];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= MenuState;
         cursor_q <= STATE_W'(1);
         enter_q  <= 1'b0;
         exit_q   <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         enter_q  <= 1'b0;
         exit_q   <= 1'b0;
         reject_q <= 1'b0;
         if (state_q == MenuState) begin
            // Priority C > L > R; lower-priority events in the same cycle are dropped.
            if (evt_c) begin
               if (cursor_en) begin
                  state_q <= cursor_q;
                  enter_q <= 1'b1;
               end else begin
                  reject_q <= 1'b1;
               end
            end else if (evt_l) begin
               cursor_q <= STATE_W'(next_cursor(32'(cursor_q), DirLeft, WRAP, NUM_APPS));
            end else if (evt_r) begin
               cursor_q <= STATE_W'(next_cursor(32'(cursor_q), DirRight, WRAP, NUM_APPS));
            end
         end else if (evt_l || !state_en) begin
            // Cursor is left alone so the menu re-highlights the app just left.
            state_q <= MenuState;
            exit_q  <= 1'b1;
         end
      end
   end

   assign bus.machine_state = state_q;
   assign bus.menu_cursor   = cursor_q;
   assign bus.enter_pulse   = enter_q;
   assign bus.exit_pulse    = exit_q;
   assign bus.reject_pulse  = reject_q;

endmodule

// File: tb/tb_menu_mode_controller.sv
// Bench for menu_mode_controller: a wrapping and a saturating instance share stimulus and
// are compared every cycle against a window-based reference model, plus literal checks.
module tb_menu_mode_controller;

   localparam int unsigned R = 4;
   localparam int unsigned N = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_c = 1'b0;
   logic       btn_l = 1'b0;
   logic       btn_r = 1'b0;
   logic [7:0] app_en = 8'hFF;

   int n_total = 0;
   int n_pass  = 0;
   int n_ent_w = 0;
   int n_ex_w  = 0;
   int n_rej_w = 0;

   menu_mode_controller_if #(.NUM_APPS(N)) bus_w ();
   menu_mode_controller_if #(.NUM_APPS(N)) bus_s ();

   assign bus_w.btnC = btn_c;
   assign bus_w.btnL = btn_l;
   assign bus_w.btnR = btn_r;
   assign bus_w.app_enable = app_en;
   assign bus_s.btnC = btn_c;
   assign bus_s.btnL = btn_l;
   assign bus_s.btnR = btn_r;
   assign bus_s.app_enable = app_en;

   menu_mode_controller #(.NUM_APPS(N), .RELEASE_CYCLES(R), .WRAP(1'b1)) dut_w (
      .clock (clock),
      .reset (reset),
      .bus   (bus_w)
   );

   menu_mode_controller #(.NUM_APPS(N), .RELEASE_CYCLES(R), .WRAP(1'b0)) dut_s (
      .clock (clock),
      .reset (reset),
      .bus   (bus_s)
   );

   always #5 clock = ~clock;

   // Reference model: index 0 = saturating instance, 1 = wrapping instance.
   // Buttons: 0 = C, 1 = L, 2 = R.
   int m_mode [2] = '{0, 0};
   int m_cur  [2] = '{1, 1};
   bit m_ent  [2] = '{0, 0};
   bit m_ex   [2] = '{0, 0};
   bit m_rej  [2] = '{0, 0};
   bit raw_d1 [3] = '{0, 0, 0};
   bit raw_d2 [3] = '{0, 0, 0};
   bit evt_p  [3] = '{0, 0, 0};
   bit hist   [3][R+1];
   bit raw_now[3];

   task automatic model_clear();
      for (int w = 0; w < 2; w++) begin
         m_mode[w] = 0;
         m_cur[w]  = 1;
         m_ent[w]  = 0;
         m_ex[w]   = 0;
         m_rej[w]  = 0;
      end
      for (int b = 0; b < 3; b++) begin
         raw_d1[b] = 0;
         raw_d2[b] = 0;
         evt_p[b]  = 0;
         for (int j = 0; j <= R; j++) hist[b][j] = 0;
      end
   endtask

   task automatic fsm_step(input int w);
      m_ent[w] = 0;
      m_ex[w]  = 0;
      m_rej[w] = 0;
      if (m_mode[w] == 0) begin
         if (evt_p[0]) begin
            if (app_en[m_cur[w]-1]) begin
               m_mode[w] = m_cur[w];
               m_ent[w]  = 1;
            end else begin
               m_rej[w] = 1;
            end
         end else if (evt_p[1]) begin
            m_cur[w] = (m_cur[w] == 1) ? ((w == 1) ? N : 1) : m_cur[w] - 1;
         end else if (evt_p[2]) begin
            m_cur[w] = (m_cur[w] == N) ? ((w == 1) ? 1 : N) : m_cur[w] + 1;
         end
      end else if (evt_p[1] || !app_en[m_mode[w]-1]) begin
         m_mode[w] = 0;
         m_ex[w]   = 1;
      end
   endtask

   // A button fires when its synchronized history is one high sample followed by R lows;
   // the synchronizer is modelled as a two-sample delay of the raw input.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         model_clear();
      end else begin
         raw_now[0] = btn_c;
         raw_now[1] = btn_l;
         raw_now[2] = btn_r;
         for (int w = 0; w < 2; w++) fsm_step(w);
         for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < R; j++) hist[b][j] = hist[b][j+1];
            hist[b][R] = raw_d2[b];
            evt_p[b] = hist[b][0];
            for (int j = 1; j <= R; j++) if (hist[b][j]) evt_p[b] = 0;
            raw_d2[b] = raw_d1[b];
            raw_d1[b] = raw_now[b];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic cmp(input string name, input logic [3:0] st, input logic [3:0] cur,
                      input logic e, input logic x, input logic r, input int w);
      check(name, 32'({st, cur, e, x, r}),
            32'({4'(m_mode[w]), 4'(m_cur[w]), m_ent[w], m_ex[w], m_rej[w]}));
   endtask

   always @(negedge clock) begin
      n_ent_w += 32'(bus_w.enter_pulse);
      n_ex_w  += 32'(bus_w.exit_pulse);
      n_rej_w += 32'(bus_w.reject_pulse);
      cmp("cycle_wrap", bus_w.machine_state, bus_w.menu_cursor, bus_w.enter_pulse,
          bus_w.exit_pulse, bus_w.reject_pulse, 1);
      cmp("cycle_sat", bus_s.machine_state, bus_s.menu_cursor, bus_s.enter_pulse,
          bus_s.exit_pulse, bus_s.reject_pulse, 0);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic look();
      @(negedge clock);
      #1;
   endtask

   task automatic set_btns(input logic [2:0] m);
      btn_c = m[0];
      btn_l = m[1];
      btn_r = m[2];
   endtask

   task automatic tap(input logic [2:0] m, input int hold);
      set_btns(m);
      step(hold);
      set_btns(3'b000);
      step(R + 6);
   endtask

   int ref_cnt;

   initial begin
      for (int b = 0; b < 3; b++) for (int j = 0; j <= R; j++) hist[b][j] = 0;
      step(3);
      reset = 1'b0;
      step(100);
      look();
      check("rst_state", 32'(bus_w.machine_state), 0);
      check("rst_cursor", 32'(bus_w.menu_cursor), 1);
      check("rst_no_pulses", n_ent_w + n_ex_w + n_rej_w, 0);

      // Left at cursor 1: wraps to N on one instance, sticks at 1 on the other.
      tap(3'b010, 3);
      look();
      check("left_wrap", 32'(bus_w.menu_cursor), 8);
      check("left_sat", 32'(bus_s.menu_cursor), 1);

      // Exact release latency: event on edge R+2 after the fall, cursor moves one edge later.
      btn_r = 1'b1;
      step(3);
      btn_r = 1'b0;
      repeat (6) @(posedge clock);
      look();
      check("lat_before", 32'(bus_w.menu_cursor), 8);
      @(posedge clock);
      look();
      check("lat_wrap_right", 32'(bus_w.menu_cursor), 1);
      check("lat_sat_right", 32'(bus_s.menu_cursor), 2);
      step(R + 2);

      tap(3'b100, 2);
      tap(3'b100, 2);
      look();
      check("cursor3", 32'(bus_w.menu_cursor), 3);
      check("cursor4_sat", 32'(bus_s.menu_cursor), 4);

      ref_cnt = n_ent_w;
      tap(3'b001, 3);
      look();
      check("enter_state", 32'(bus_w.machine_state), 3);
      check("enter_count", n_ent_w - ref_cnt, 1);

      ref_cnt = n_ex_w;
      tap(3'b010, 3);
      look();
      check("exit_state", 32'(bus_w.machine_state), 0);
      check("exit_cursor_kept", 32'(bus_w.menu_cursor), 3);
      check("exit_count", n_ex_w - ref_cnt, 1);

      // Entry 3 disabled: rejected on the wrapping instance, entry 4 allowed on the other.
      app_en = 8'hFB;
      ref_cnt = n_rej_w;
      tap(3'b001, 3);
      look();
      check("reject_state", 32'(bus_w.machine_state), 0);
      check("reject_count", n_rej_w - ref_cnt, 1);
      check("sat_enter4", 32'(bus_s.machine_state), 4);
      app_en = 8'hFF;
      tap(3'b010, 3);

      // Bounce: low 2, high 1, then low; exactly one event counted from the last fall.
      btn_l = 1'b1;
      step(3);
      btn_l = 1'b0;
      step(2);
      btn_l = 1'b1;
      step(1);
      btn_l = 1'b0;
      repeat (6) @(posedge clock);
      look();
      check("bounce_before", 32'(bus_w.menu_cursor), 2);
      @(posedge clock);
      look();
      check("bounce_once", 32'(bus_w.menu_cursor), 1);
      step(R + 6);
      look();
      check("bounce_final", 32'(bus_w.menu_cursor), 1);

      // C and R released together: only the enter happens.
      tap(3'b101, 3);
      look();
      check("cr_state", 32'(bus_w.machine_state), 1);
      check("cr_cursor", 32'(bus_w.menu_cursor), 1);

      tap(3'b010, 3);
      repeat (4) tap(3'b100, 2);
      tap(3'b001, 2);
      look();
      check("app5", 32'(bus_w.machine_state), 5);

      // Reset in the middle of a release count discards the pending exit.
      ref_cnt = n_ex_w;
      btn_l = 1'b1;
      step(3);
      btn_l = 1'b0;
      step(3);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(R + 10);
      look();
      check("rst_mid_state", 32'(bus_w.machine_state), 0);
      check("rst_mid_cursor", 32'(bus_w.menu_cursor), 1);
      check("rst_mid_no_exit", n_ex_w - ref_cnt, 0);

      // Disabling the running app forces an exit on the next edge.
      repeat (4) tap(3'b100, 2);
      tap(3'b001, 2);
      app_en = 8'hEF;
      @(posedge clock);
      look();
      check("forced_state", 32'(bus_w.machine_state), 0);
      check("forced_pulse", 32'(bus_w.exit_pulse), 1);
      app_en = 8'hFF;
      step(5);

      // Random phase: per-cycle model comparison does the checking.
      for (int c = 0; c < 4000; c++) begin
         if (btn_c) btn_c = ($urandom_range(0, 2) != 0); else btn_c = ($urandom_range(0, 9) == 0);
         if (btn_l) btn_l = ($urandom_range(0, 2) != 0); else btn_l = ($urandom_range(0, 9) == 0);
         if (btn_r) btn_r = ($urandom_range(0, 2) != 0); else btn_r = ($urandom_range(0, 9) == 0);
         if ((c % 256) == 0) app_en = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
         reset = (c >= 2000 && c < 2002);
         step(1);
      end
      set_btns(3'b000);
      reset = 1'b0;
      step(R + 6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
